// File: rtl/spi_bridge_pkg.sv
// Shared types and constants for the SPI-to-TinyQV peripheral bridge: FSM states,
// transaction width encodings, the read-data width mask and the timeout fill word.
package spi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RESP,
    ST_RELEASE
  } state_t;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;
  localparam logic [1:0] W_NONE = 2'b11;

  localparam logic [31:0] DEADBEEF = 32'hDEADBEEF;

  // Bits of a 32-bit bus word that are meaningful for a given transaction width.
  function automatic logic [31:0] width_mask(input logic [1:0] w);
    case (w)
      W_BYTE:  return 32'h0000_00FF;
      W_HALF:  return 32'h0000_FFFF;
      W_WORD:  return 32'hFFFF_FFFF;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/spi_bridge_timeout.sv
// Read-wait watchdog for the bridge: counts enabled cycles spent in READ and flags
// the cycle in which the wait reaches TIMEOUT_CYCLES. Only built with SPI_BRIDGE_TIMEOUT_EN.
module spi_bridge_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rstb,
  input  logic ena,
  input  logic count_en,
  output logic expired
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // The count sits at zero outside READ, so every READ entry starts from a clean count.
  always_comb begin
    cnt_d = count_en ? cnt_q + 8'd1 : 8'd0;
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      cnt_q <= 8'd0;
    end else if (ena) begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = count_en && (cnt_d == 8'(TIMEOUT_CYCLES));

endmodule

// File: rtl/spi_periph_bridge.sv
// Turns SPI front-end register strobes into one TinyQV peripheral bus access per frame.
// Optional read timeout with sticky bus_err is enabled by defining SPI_BRIDGE_TIMEOUT_EN.
module spi_periph_bridge
  import spi_bridge_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int REG_W  = 32
`ifdef SPI_BRIDGE_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic              reg_rw,
  input  logic [1:0]        txn_width,
  input  logic              reg_addr_v,
  input  logic [REG_W-1:0]  reg_data_o,
  input  logic              reg_data_o_dv,
  output logic [REG_W-1:0]  reg_data_i,
  output logic              reg_data_i_dv,
  output logic [ADDR_W-1:0] address,
  output logic [REG_W-1:0]  data_in,
  output logic [1:0]        data_write_n,
  output logic [1:0]        data_read_n,
  input  logic [REG_W-1:0]  data_out,
  input  logic              data_ready,
  output logic              bus_err
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [REG_W-1:0]  wdata_q, wdata_d;
  logic [REG_W-1:0]  rdata_q, rdata_d;
  logic [1:0]        width_q, width_d;
  logic              timeout_hit;

`ifdef SPI_BRIDGE_TIMEOUT_EN
  logic berr_q, berr_d;

  spi_bridge_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rstb     (rstb),
    .ena      (ena),
    .count_en (state_q == ST_READ),
    .expired  (timeout_hit)
  );

  always_ff @(posedge clk) begin
    if (!rstb) begin
      berr_q <= 1'b0;
    end else if (ena) begin
      berr_q <= berr_d;
    end
  end

  assign bus_err = berr_q;
`else
  assign timeout_hit = 1'b0;
  assign bus_err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      width_q <= W_NONE;
    end else if (ena) begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      width_q <= width_d;
    end
  end

  // A write request takes priority; a width-NONE write is dropped while a width-NONE
  // read is answered immediately with zero so the front end is never left waiting.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    width_d = width_q;
`ifdef SPI_BRIDGE_TIMEOUT_EN
    berr_d  = berr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (reg_data_o_dv && reg_rw) begin
          if (txn_width != W_NONE) begin
            addr_d  = reg_addr;
            wdata_d = reg_data_o;
            width_d = txn_width;
            state_d = ST_WRITE;
          end
        end else if (reg_addr_v && !reg_rw) begin
          addr_d  = reg_addr;
          width_d = txn_width;
          if (txn_width == W_NONE) begin
            rdata_d = '0;
            state_d = ST_RESP;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_READ: begin
        if (data_ready) begin
          rdata_d = data_out & width_mask(width_q);
          state_d = ST_RESP;
        end else if (timeout_hit) begin
          rdata_d = DEADBEEF;
`ifdef SPI_BRIDGE_TIMEOUT_EN
          berr_d  = 1'b1;
`endif
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_RELEASE;
      // Holding here until the frame ends keeps one bus read per SPI frame.
      ST_RELEASE: begin
        if (!reg_addr_v) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_write_n  = W_NONE;
    data_read_n   = W_NONE;
    reg_data_i_dv = 1'b0;
    case (state_q)
      ST_WRITE: data_write_n  = width_q;
      ST_READ:  data_read_n   = width_q;
      ST_RESP:  reg_data_i_dv = 1'b1;
      default: ;
    endcase
  end

  assign address    = addr_q;
  assign data_in    = wdata_q;
  assign reg_data_i = rdata_q;

endmodule
